// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register built as a 2-entry skid buffer with registered in_ready.
// Optional stall counter output enabled by defining EX_MEM_PERF_EN.
`timescale 1ns/1ps

module ex_mem_reg #(
    parameter int unsigned ALU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALU_WIDTH-1:0] in_alu_out,
    input  logic [ALU_WIDTH-1:0] in_store_data,
    input  logic [4:0]           in_rd,
    input  logic [2:0]           in_funct3,
    input  logic                 in_reg_wr,
    input  logic                 in_mem_rd,
    input  logic                 in_mem_wr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALU_WIDTH-1:0] out_alu_out,
    output logic [ALU_WIDTH-1:0] out_store_data,
    output logic [4:0]           out_rd,
    output logic [2:0]           out_funct3,
    output logic                 out_reg_wr,
    output logic                 out_mem_rd,
    output logic                 out_mem_wr
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int unsigned RD_W  = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] alu_out;
        logic [ALU_WIDTH-1:0] store_data;
        logic [RD_W-1:0]      rd;
        logic [F3_W-1:0]      funct3;
        logic                 reg_wr;
        logic                 mem_rd;
        logic                 mem_wr;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    entry_t incoming;
    logic   in_xfer;
    logic   out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // x0 is hardwired to zero, so a write to it is dropped at capture
    always_comb begin
        incoming.alu_out    = in_alu_out;
        incoming.store_data = in_store_data;
        incoming.rd         = in_rd;
        incoming.funct3     = in_funct3;
        incoming.reg_wr     = in_reg_wr && (in_rd != RD_W'(0));
        incoming.mem_rd     = in_mem_rd;
        incoming.mem_wr     = in_mem_wr;
    end

    // Next-state and entry movement; flush overrides any transfer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = incoming;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = incoming;
                    end else if (in_xfer) begin
                        skid_d  = incoming;
                        state_d = TWO;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_alu_out    = main_q.alu_out;
    assign out_store_data = main_q.store_data;
    assign out_rd         = main_q.rd;
    assign out_funct3     = main_q.funct3;
    assign out_reg_wr     = main_q.reg_wr;
    assign out_mem_rd     = main_q.mem_rd;
    assign out_mem_wr     = main_q.mem_wr;

`ifdef EX_MEM_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Counts cycles where the head is offered but not taken; wraps freely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg (stall counter checks when EX_MEM_PERF_EN is defined).
`timescale 1ns/1ps

module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_out;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic        in_reg_wr;
    logic        in_mem_rd;
    logic        in_mem_wr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_out;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic        out_reg_wr;
    logic        out_mem_rd;
    logic        out_mem_wr;
`ifdef EX_MEM_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(.ALU_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_out     (in_alu_out),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_funct3      (in_funct3),
        .in_reg_wr      (in_reg_wr),
        .in_mem_rd      (in_mem_rd),
        .in_mem_wr      (in_mem_wr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_out    (out_alu_out),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_funct3     (out_funct3),
        .out_reg_wr     (out_reg_wr),
        .out_mem_rd     (out_mem_rd),
        .out_mem_wr     (out_mem_wr)
`ifdef EX_MEM_PERF_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_alu_out = '0;
        in_store_data = '0;
        in_rd = '0;
        in_funct3 = '0;
        in_reg_wr = 1'b0;
        in_mem_rd = 1'b0;
        in_mem_wr = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu", out_alu_out, 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        tick();
        reset = 1'b0;

        // single transfer, one-cycle latency
        in_valid = 1'b1; in_alu_out = 32'h5; in_rd = 5'd3; in_reg_wr = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_alu", out_alu_out, 32'h5);
        chk("lat_rd", 32'(out_rd), 32'd3);
        chk("lat_reg_wr", 32'(out_reg_wr), 32'd1);
        tick();
        chk("lat_drain", 32'(out_valid), 32'd0);

        // fill both entries with the consumer stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_alu_out = 32'h11; in_rd = 5'd1;
        tick();
        chk("fill1_ready", 32'(in_ready), 32'd1);
        chk("fill1_alu", out_alu_out, 32'h11);
        in_alu_out = 32'h22; in_rd = 5'd2;
        tick();
        in_valid = 1'b0;
        chk("fill2_ready", 32'(in_ready), 32'd0);
        chk("fill2_alu", out_alu_out, 32'h11);
        tick();
        chk("stall_hold_alu", out_alu_out, 32'h11);
        chk("stall_hold_rd", 32'(out_rd), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("drainB_valid", 32'(out_valid), 32'd1);
        chk("drainB_alu", out_alu_out, 32'h22);
        chk("drainB_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // streaming: one entry per cycle, in_ready never drops
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_alu_out = 32'(i); in_rd = 5'(i);
            tick();
            chk("stream_alu", out_alu_out, 32'(i));
            chk("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_empty", 32'(out_valid), 32'd0);

        // x0 destination suppresses reg_wr
        in_valid = 1'b1; in_rd = 5'd0; in_reg_wr = 1'b1; in_alu_out = 32'hDEAD_BEEF;
        in_store_data = 32'hCAFE_F00D; in_funct3 = 3'd5; in_mem_rd = 1'b1; in_mem_wr = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("x0_reg_wr", 32'(out_reg_wr), 32'd0);
        chk("x0_alu", out_alu_out, 32'hDEAD_BEEF);
        chk("x0_sdata", out_store_data, 32'hCAFE_F00D);
        chk("x0_funct3", 32'(out_funct3), 32'd5);
        chk("x0_mem_rd", 32'(out_mem_rd), 32'd1);
        chk("x0_mem_wr", 32'(out_mem_wr), 32'd0);
        tick();
        in_mem_rd = 1'b0; in_store_data = '0; in_funct3 = '0; in_rd = 5'd4;

        // flush in TWO with a simultaneous offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_alu_out = 32'hA1;
        tick();
        in_alu_out = 32'hA2;
        tick();
        chk("pre_flush_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; in_alu_out = 32'hBAD;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_alu_out = 32'h33;
        tick();
        in_valid = 1'b0;
        chk("post_flush_alu", out_alu_out, 32'h33);
        tick();
        chk("post_flush_empty", 32'(out_valid), 32'd0);

        // clean counter base, then stall with one entry held
        reset = 1'b1; #2; reset = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_alu_out = 32'h77;
        tick();
        in_valid = 1'b0;
        chk("stall_valid", 32'(out_valid), 32'd1);
        tick(); tick(); tick(); tick();
`ifdef EX_MEM_PERF_EN
        chk("stall_cnt4", stall_cnt, 32'd4);
`endif
        // asynchronous reset mid-cycle clears everything at once
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", 32'(out_valid), 32'd0);
        chk("areset_alu", out_alu_out, 32'd0);
        chk("areset_ready", 32'(in_ready), 32'd1);
`ifdef EX_MEM_PERF_EN
        chk("areset_cnt", stall_cnt, 32'd0);
`endif
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_alu_out = 32'h99; in_rd = 5'd7;
        tick();
        in_valid = 1'b0;
        chk("after_rst_alu", out_alu_out, 32'h99);
        chk("after_rst_valid", 32'(out_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
